muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin an operation.
REQ-005 SHALL have port mdOp, input, 3 bits, operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port srcA, input, WIDTH bits, operand A, the same register-file operand that drives the ALU.
REQ-007 SHALL have port srcB, input, WIDTH bits, operand B, the same register-file operand that drives the ALU.
REQ-008 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit, single-cycle pulse marking mdResult valid.
REQ-010 SHALL have port mdResult, output, WIDTH bits, result fed to the result mux beside ALUResult.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 SHALL, in IDLE with start=1 at edge 0, latch mdOp, srcA and srcB, enter CALC and assert busy from cycle 1.
REQ-013 SHALL, in CALC, perform exactly WIDTH iterations: radix-2 shift-add for multiply, restoring shift-subtract for divide, one iteration per cycle, with an internal counter 0..WIDTH-1.
REQ-014 SHALL enter DONE after the final iteration, i.e. in cycle WIDTH+1; in DONE, done=1 and busy=0 for one cycle, then return to IDLE.
REQ-015 SHALL drive busy=1 in CALC only.
REQ-016 SHALL keep mdResult stable from DONE until the next DONE, and update it at no other time.
REQ-017 SHALL ignore start while in CALC or DONE, with latched operands unaffected.
REQ-018 SHALL accept a start in IDLE on the cycle immediately after DONE (back-to-back issue).
REQ-019 SHALL, for MUL, return the low WIDTH bits of the 2*WIDTH product.
REQ-020 SHALL, for MULH/MULHSU/MULHU, return the high WIDTH bits with operands treated as signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-021 SHALL, for DIV/REM, divide signed magnitudes, with quotient truncated toward zero and remainder sign equal to the dividend sign.
REQ-022 SHALL, for divide by zero, return a quotient of all ones and a remainder equal to srcA.
REQ-023 SHALL, for signed overflow (srcA=0x80000000, srcB=0xFFFFFFFF), return DIV=0x80000000 and REM=0.

Reset
REQ-024 SHALL, when reset is asserted, immediately force state=IDLE, busy=0, done=0, mdResult=0 and counter=0, regardless of the clock.
REQ-025 SHALL, on reset during CALC, abort the operation, produce no done pulse, and leave the unit ready for start on the first edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro MULDIV_EARLY_OUT_EN defined, bypass CALC and go IDLE->DONE at cycle 1 when, for divide, srcB=0 or the REQ-023 overflow case applies, or, for multiply, srcA=0 or srcB=0; the result SHALL equal the full computation.
REQ-027 SHALL, without MULDIV_EARLY_OUT_EN, give every operation the fixed WIDTH+1 cycle latency of REQ-014.

Verification
REQ-028 SHALL pass: MUL srcA=7, srcB=6 -> done at cycle 33, mdResult=0x0000002A, busy high cycles 1..32.
REQ-029 SHALL pass: MULH srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> mdResult=0; MULHU with the same operands -> 0xFFFFFFFE.
REQ-030 SHALL pass: DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-031 SHALL pass: DIVU srcA=5, srcB=0 -> 0xFFFFFFFF; REMU with the same operands -> 5; with MULDIV_EARLY_OUT_EN, done at cycle 1.
REQ-032 SHALL pass: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; a second start pulse at cycle 10 is ignored and a single done pulse occurs.
REQ-033 SHALL pass: reset asserted at cycle 15 of a DIVU -> busy=0 immediately, no done pulse; a new MUL 3×3 after release -> 9.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative integer multiply/divide unit sitting beside the ALU. A request is
// accepted in IDLE, the operation runs for WIDTH single-bit iterations in CALC
// (radix-2 shift-add for multiply, restoring shift-subtract for divide), and
// the result is presented for one cycle in DONE together with a done pulse.
// Signed operations are handled by working on operand magnitudes and fixing
// the sign of the result after the last iteration.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN - trivial cases (multiply by zero, divide by zero,
//                         signed divide overflow) skip CALC and go straight
//                         to DONE one cycle after start. Without the macro
//                         every operation takes WIDTH+1 cycles.
//
// Ports:
//   clk      - clock, all state changes on its rising edge
//   reset    - asynchronous active-high reset
//   start    - request to begin an operation (only honoured in IDLE)
//   mdOp     - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   srcA     - operand A (multiplicand / dividend)
//   srcB     - operand B (multiplier / divisor)
//   busy     - high while iterating in CALC
//   done     - one-cycle pulse, mdResult valid
//   mdResult - result, held from one DONE until the next
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mdResult
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Latched operation context. r_hi/r_lo are shared: for multiply they hold
    // the running {partial product, multiplier}; for divide they hold
    // {partial remainder, dividend/quotient}.
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opB;
    logic             r_negRes;
    logic             r_negRem;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;

    // Operand conditioning: which operands are signed for this opcode, and
    // their magnitudes. MUL only needs the low half, so it is treated as
    // unsigned. Divide ops are signed when mdOp[0] is clear.
    logic             w_aSigned;
    logic             w_bSigned;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;

    always_comb begin
        w_aSigned = 1'b0;
        w_bSigned = 1'b0;
        if (mdOp[2]) begin
            w_aSigned = ~mdOp[0];
            w_bSigned = ~mdOp[0];
        end else begin
            w_aSigned = (mdOp[1:0] == 2'd1) || (mdOp[1:0] == 2'd2);
            w_bSigned = (mdOp[1:0] == 2'd1);
        end
    end

    assign w_aNeg = w_aSigned & srcA[WIDTH-1];
    assign w_bNeg = w_bSigned & srcB[WIDTH-1];
    assign w_aMag = w_aNeg ? -srcA : srcA;
    assign w_bMag = w_bNeg ? -srcB : srcB;

    // One iteration of each algorithm. Multiply adds the multiplicand when the
    // current multiplier bit is set and shifts the 2*WIDTH accumulator right.
    // Divide shifts the next dividend bit into the remainder and subtracts the
    // divisor if it fits, shifting the quotient bit in from the right.
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_nextHi;
    logic [WIDTH-1:0] w_nextLo;

    assign w_addend = r_lo[0] ? r_opB : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_opB};
    assign w_fits   = ~w_diff[WIDTH];

    always_comb begin
        w_nextHi = r_hi;
        w_nextLo = r_lo;
        if (r_op[2]) begin
            w_nextHi = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_nextLo = {r_lo[WIDTH-2:0], w_fits};
        end else begin
            w_nextHi = w_sum[WIDTH:1];
            w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied to the values produced by the final iteration.
    // Divide by zero naturally yields an all-ones magnitude quotient, but the
    // sign fix-up would corrupt it, so the quotient is forced to all ones.
    // The remainder of a divide by zero is the dividend magnitude, which the
    // sign fix-up turns back into srcA.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_finalResult;
    logic               w_divZero;

    assign w_prod    = {w_nextHi, w_nextLo};
    assign w_prodFix = r_negRes ? -w_prod : w_prod;
    assign w_divZero = (r_opB == '0);
    assign w_quo     = w_divZero ? '1 : (r_negRes ? -w_nextLo : w_nextLo);
    assign w_rem     = r_negRem ? -w_nextHi : w_nextHi;

    always_comb begin
        w_finalResult = '0;
        if (r_op[2]) begin
            w_finalResult = r_op[1] ? w_rem : w_quo;
        end else if (r_op == 3'd0) begin
            w_finalResult = w_prodFix[WIDTH-1:0];
        end else begin
            w_finalResult = w_prodFix[2*WIDTH-1:WIDTH];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Early-out detection on the live operands in IDLE. The overflow case is
    // only meaningful for the signed divide ops.
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_bZero;
    logic             w_aZero;
    logic             w_ovf;
    logic             w_earlyOut;
    logic [WIDTH-1:0] w_earlyResult;

    assign w_bZero = (srcB == '0);
    assign w_aZero = (srcA == '0);
    assign w_ovf   = mdOp[2] & ~mdOp[0] & (srcA == MIN_NEG) & (srcB == '1);

    always_comb begin
        w_earlyOut    = 1'b0;
        w_earlyResult = '0;
        if (mdOp[2]) begin
            if (w_bZero) begin
                w_earlyOut    = 1'b1;
                w_earlyResult = mdOp[1] ? srcA : '1;
            end else if (w_ovf) begin
                w_earlyOut    = 1'b1;
                w_earlyResult = mdOp[1] ? '0 : MIN_NEG;
            end
        end else if (w_aZero || w_bZero) begin
            w_earlyOut    = 1'b1;
            w_earlyResult = '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Start is only looked at in IDLE, so requests arriving
    // during CALC or DONE are dropped.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
                    w_nextState = w_earlyOut ? DONE : CALC;
`else
                    w_nextState = CALC;
`endif
                end
            end
            CALC: begin
                if (r_count == LAST_ITER) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on an accepted start, step the algorithm in
    // CALC, and load the result register only when entering DONE so it stays
    // stable between completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opB    <= '0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= mdOp;
                        r_hi     <= '0;
                        r_lo     <= w_aMag;
                        r_opB    <= w_bMag;
                        r_negRes <= w_aNeg ^ w_bNeg;
                        r_negRem <= w_aNeg;
                        r_count  <= '0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_earlyOut) begin
                            r_result <= w_earlyResult;
                        end
`endif
                    end
                end
                CALC: begin
                    r_hi <= w_nextHi;
                    r_lo <= w_nextLo;
                    if (r_count == LAST_ITER) begin
                        r_count  <= '0;
                        r_result <= w_finalResult;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state == CALC);
    assign done     = (r_state == DONE);
    assign mdResult = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit (WIDTH=32). A reference model computes each
// result with plain 64-bit arithmetic and tracks the expected latency as a
// cycle count from acceptance; a compare process checks busy, done and
// mdResult against it on every cycle. Directed vectors also carry hand-worked
// results and latencies.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   mdOp = '0;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] mdResult;

    int checks = 0;
    int failures = 0;
    int edgeCount = 0;
    bit checking = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdOp     (mdOp),
        .srcA     (srcA),
        .srcB     (srcB),
        .busy     (busy),
        .done     (done),
        .mdResult (mdResult)
    );

    // Free-running clock; posedges at 5, 15, ... and negedges at 10, 20, ...
    always #5 clk = ~clk;

    // Edge counter used to measure latency relative to the accepting edge.
    always @(posedge clk) edgeCount++;

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [31:0] refResult(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Cycles from the accepting edge to the done cycle.
    function automatic int refLatency(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        bit trivial;
        if (op[2]) begin
            trivial = (b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        end else begin
            trivial = (a == 0) || (b == 0);
        end
        return (EARLY && trivial) ? 1 : W + 1;
    endfunction

    // Model state: mPhase counts cycles since acceptance (0 means idle),
    // mResult is the value mdResult must hold.
    int          mPhase = 0;
    int          mLatency = W + 1;
    logic [31:0] mPending = '0;
    logic [31:0] mResult = '0;

    // Advance the model on each clock edge; reset clears everything at once.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPhase  = 0;
            mResult = '0;
        end else begin
            if (mPhase != 0) begin
                mPhase++;
                if (mPhase > mLatency) mPhase = 0;
            end else if (start) begin
                mPhase   = 1;
                mLatency = refLatency(mdOp, srcA, srcB);
                mPending = refResult(mdOp, srcA, srcB);
            end
            if (mPhase != 0 && mPhase == mLatency) mResult = mPending;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, compare the DUT outputs with what the model says they are.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cyc_busy", {31'b0, busy},
                        {31'b0, (mPhase >= 1 && mPhase < mLatency)});
            checkOutput("cyc_done", {31'b0, done},
                        {31'b0, (mPhase != 0 && mPhase == mLatency)});
            checkOutput("cyc_result", mdResult, mResult);
        end
    end

    int issueEdge = 0;

    // Drive one request; the caller is positioned just after a negedge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        mdOp      = op;
        srcA      = a;
        srcB      = b;
        start     = 1'b1;
        issueEdge = edgeCount;
    endtask

    // Wait for the done pulse (bounded), scrambling the operand inputs while
    // the operation runs; reports the done cycle and number of busy cycles.
    task automatic waitDone(output int doneCycle, output int busyCycles);
        doneCycle  = -1;
        busyCycles = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            srcA  = $urandom;
            srcB  = $urandom;
            if (busy) busyCycles++;
            if (done) begin
                doneCycle = edgeCount - issueEdge;
                break;
            end
        end
        if (doneCycle < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          trivial;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int dc;
        int bc;
        int doneCnt;

        vecs.push_back('{"mul_7x6",     3'd0, 32'd7,        32'd6,        32'h0000002A, 1'b0});
        vecs.push_back('{"mulh_m1m1",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});
        vecs.push_back('{"mulhu_ff",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{"div_m7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0});
        vecs.push_back('{"rem_m7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"divu_5_0",    3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
        vecs.push_back('{"remu_5_0",    3'd7, 32'd5,        32'd0,        32'h00000005, 1'b1});
        vecs.push_back('{"mulhsu_m2_3", 3'd2, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"mulh_min2",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0});
        vecs.push_back('{"mul_ffff",    3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0});
        vecs.push_back('{"divu_100_7",  3'd5, 32'd100,      32'd7,        32'h0000000E, 1'b0});
        vecs.push_back('{"remu_100_7",  3'd7, 32'd100,      32'd7,        32'h00000002, 1'b0});
        vecs.push_back('{"div_7_m2",    3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{"rem_7_m2",    3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{"div_m5_0",    3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1});
        vecs.push_back('{"rem_m5_0",    3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1});
        vecs.push_back('{"mul_zero",    3'd0, 32'd0,        32'd12345,    32'h00000000, 1'b1});
        vecs.push_back('{"rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{"mulhsu_m1",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});

        // Power-on reset; outputs must read zero while reset is held.
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", mdResult, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        checking = 1'b1;

        // Directed vectors, issued back-to-back in the cycle after each DONE.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(dc, bc);
            checkOutput(vecs[i].name, mdResult, vecs[i].exp);
            checkOutput({vecs[i].name, "_lat"}, dc,
                        (EARLY && vecs[i].trivial) ? 32'd1 : 32'd33);
            checkOutput({vecs[i].name, "_model"},
                        refResult(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
            if (i == 0) checkOutput("mul_busy_cycles", bc, 32'd32);
        end

        // Signed overflow divide with a stray start mid-operation.
        @(negedge clk);
        applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF);
        doneCnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) doneCnt++;
`ifndef MULDIV_EARLY_OUT_EN
            if (c == 10) begin
                mdOp  = 3'd0;
                srcA  = 32'd1;
                srcB  = 32'd1;
                start = 1'b1;
            end
`endif
        end
        checkOutput("ovf_done_pulses", doneCnt, 32'd1);
        checkOutput("ovf_div", mdResult, 32'h80000000);

        // Reset in the middle of a DIVU, then a MUL on the first edge after release.
        @(negedge clk);
        applyStimulus(3'd5, 32'd100, 32'd7);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_result", mdResult, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        applyStimulus(3'd0, 32'd3, 32'd3);
        waitDone(dc, bc);
        checkOutput("post_reset_mul", mdResult, 32'd9);
        checkOutput("post_reset_lat", dc, 32'd33);

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
